// File: rtl/mult_share_pkg.sv
// Shared constants for the multiplier-sharing controller: FSM encoding and default sizes.
package mult_share_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/mult_share_ctrl_rr_pick.sv
// Round-robin picker: lowest requesting index at or after rr_ptr wins, as one-hot grant plus index.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] rot;
    int unsigned        pos;

    // Rotating the doubled vector puts rr_ptr at bit 0, so a plain low-first scan is round-robin.
    always_comb begin
        dbl   = {req, req};
        rot   = dbl >> rr_ptr;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                pos = i + 32'(rr_ptr);
                if (pos >= N_REQ) pos = pos - N_REQ;
                idx        = IW'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential multiplier (enable/busy/R handshake) among N_REQ requesters, round-robin,
// with a watchdog that aborts a hung job and raises a sticky error.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned W       = DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   done,
    output logic [2*W-1:0]     result,
    output logic               err,
    output logic               mul_enable,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic               mul_busy,
    input  logic [2*W-1:0]     mul_r
);

    localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [WD_W-1:0]  wd;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic [N_REQ-1:0] owner_oh;
    logic [IW-1:0]    rr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(win_idx) == i) begin
                a_sel = a_in[i*W +: W];
                b_sel = b_in[i*W +: W];
            end
        end
        owner_oh = N_REQ'(1) << owner;
        rr_next  = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            wd         <= '0;
            ack        <= '0;
            done       <= '0;
            result     <= '0;
            err        <= 1'b0;
            mul_enable <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                S_IDLE: begin
                    // A busy multiplier here is still in its own reset; grant nothing until it settles.
                    if (!mul_busy && win_any) begin
                        mul_a      <= a_sel;
                        mul_b      <= b_sel;
                        ack        <= grant;
                        owner      <= win_idx;
                        rr_ptr     <= rr_next;
                        wd         <= '0;
                        mul_enable <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mul_busy) begin
                        mul_enable <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!mul_busy) state <= S_DONE;
                end
                S_DONE: begin
                    result <= mul_r;
                    done   <= owner_oh;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Watchdog abort overrides any transition taken in the same cycle.
            if (state == S_ISSUE || state == S_RUN) begin
                if (wd == WD_W'(TIMEOUT)) begin
                    err        <= 1'b1;
                    result     <= '0;
                    done       <= owner_oh;
                    mul_enable <= 1'b0;
                    state      <= S_IDLE;
                end else begin
                    wd <= wd + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural sequential multiplier and a result scoreboard.
module tb_mult_share_ctrl;
    import mult_share_pkg::*;

    localparam int unsigned N   = 3;
    localparam int unsigned W   = 16;
    localparam int unsigned TO  = 255;
    localparam int unsigned LAT = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     ack;
    logic [N-1:0]     done;
    logic [2*W-1:0]   result;
    logic             err;
    logic             mul_enable;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_busy = 1'b1;
    logic [2*W-1:0]   mul_r    = '0;

    always #5 clk = ~clk;

    mult_share_ctrl #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .ack        (ack),
        .done       (done),
        .result     (result),
        .err        (err),
        .mul_enable (mul_enable),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_busy   (mul_busy),
        .mul_r      (mul_r)
    );

    // Multiplier model: busy while pu_hold (its own reset), stuck idle while dead, else LAT-cycle run.
    logic        pu_hold = 1'b1;
    logic        dead    = 1'b0;
    logic [W-1:0] op_a   = '0;
    logic [W-1:0] op_b   = '0;
    int unsigned run_cnt = 0;

    always @(posedge clk) begin
        if (pu_hold) begin
            mul_busy <= 1'b1;
        end else if (dead) begin
            mul_busy <= 1'b0;
        end else if (!mul_busy && mul_enable) begin
            mul_busy <= 1'b1;
            op_a     <= mul_a;
            op_b     <= mul_b;
            run_cnt  <= LAT;
            mul_r    <= 32'hDEAD_BEEF;
        end else if (mul_busy) begin
            if (run_cnt == 0) begin
                mul_busy <= 1'b0;
                mul_r    <= {16'b0, op_a} * {16'b0, op_b};
            end else begin
                run_cnt <= run_cnt - 1;
            end
        end
    end

    typedef struct {
        int unsigned    owner;
        logic [2*W-1:0] res;
    } exp_t;

    int unsigned ack_q[$];
    exp_t        done_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic push_job(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.owner = i;
        e.res   = {16'b0, a} * {16'b0, b};
        ack_q.push_back(i);
        done_q.push_back(e);
    endtask

    task automatic wait_ack(input string tag);
        bit          seen = 1'b0;
        int unsigned o;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ack !== '0) seen = 1'b1;
        end
        o = ack_q.pop_front();
        chk({tag, "_ack_seen"}, 64'(seen), 64'd1);
        if (seen) chk({tag, "_ack_onehot"}, 64'(ack), 64'(3'b001 << o));
    endtask

    task automatic wait_done(input string tag, input int limit, output int cycles);
        bit   seen = 1'b0;
        exp_t e;
        cycles = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (done !== '0) seen = 1'b1;
        end
        e = done_q.pop_front();
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_done_onehot"}, 64'(done), 64'(3'b001 << e.owner));
            chk({tag, "_result"}, 64'(result), 64'(e.res));
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_mul_enable"}, 64'(mul_enable), 64'd0);
        chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
        chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
        chk({tag, "_state"}, 64'(dut.state), 64'(S_IDLE));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  early;
        bit  reached;
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;

        // Multiplier still busy after power-up: request must not be granted.
        set_op(0, 16'd3, 16'd5);
        push_job(0, 16'd3, 16'd5);
        req   = 3'b001;
        early = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack !== '0) early = 1'b1;
        end
        chk("pu_no_ack", 64'(early), 64'd0);
        pu_hold = 1'b0;
        wait_ack("single");
        req = '0;
        wait_done("single", 200, cyc);
        chk("single_err", 64'(err), 64'd0);
        chk("single_mul_a_hold", 64'(mul_a), 64'd3);

        // Maximum operands.
        set_op(0, 16'hFFFF, 16'hFFFF);
        push_job(0, 16'hFFFF, 16'hFFFF);
        req = 3'b001;
        wait_ack("max");
        req = '0;
        wait_done("max", 200, cyc);
        repeat (4) @(negedge clk);
        chk("max_result_hold", 64'(result), 64'hFFFE_0001);

        // Fresh reset so rr_ptr starts at 0 for the round-robin sequence.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        set_op(0, 16'd11, 16'd13);
        set_op(1, 16'd1000, 16'd2000);
        set_op(2, 16'hABCD, 16'h1234);
        push_job(0, 16'd11, 16'd13);
        push_job(1, 16'd1000, 16'd2000);
        push_job(2, 16'hABCD, 16'h1234);
        push_job(0, 16'd11, 16'd13);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("rr%0d", k));
            if (k == 3) req = '0;
            wait_done($sformatf("rr%0d", k), 200, cyc);
        end

        // Reset while the multiplier is running: job is dropped with no done.
        set_op(1, 16'd100, 16'd200);
        ack_q.push_back(1);
        req = 3'b010;
        wait_ack("rst_run");
        req     = '0;
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk);
            if (mul_busy === 1'b1 && mul_enable === 1'b0) reached = 1'b1;
        end
        chk("rst_run_reached", 64'(reached), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("rst_run");
        rst_n = 1'b1;
        early = 1'b0;
        repeat (LAT + 40) begin
            @(negedge clk);
            if (done !== '0) early = 1'b1;
        end
        chk("rst_run_no_done", 64'(early), 64'd0);

        // Hung multiplier: watchdog abort with sticky error.
        dead = 1'b1;
        set_op(2, 16'd77, 16'd88);
        ack_q.push_back(2);
        begin
            exp_t e;
            e.owner = 2;
            e.res   = '0;
            done_q.push_back(e);
        end
        req = 3'b100;
        wait_ack("wdog");
        req = '0;
        wait_done("wdog", TO + 50, cyc);
        chk("wdog_min_wait", 64'(cyc >= TO), 64'd1);
        chk("wdog_err", 64'(err), 64'd1);
        @(negedge clk);
        chk("wdog_enable_low", 64'(mul_enable), 64'd0);
        dead = 1'b0;

        set_op(0, 16'd7, 16'd9);
        push_job(0, 16'd7, 16'd9);
        req = 3'b001;
        wait_ack("post_err");
        req = '0;
        wait_done("post_err", 200, cyc);
        chk("post_err_sticky", 64'(err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
